// File: rtl/uart_bridge_fifo.sv
// Buffered bridge between core logic and the board UART port banks.
// TX FIFO drains into a strobed transmitter; RX FIFO fills on rxready rising edges.
module uart_bridge_fifo #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                       hz100,
  input  logic                       reset,
  input  logic                       tx_wr,
  input  logic [WIDTH-1:0]           tx_wdata,
  output logic                       tx_full,
  output logic [$clog2(DEPTH):0]     tx_count,
  output logic [WIDTH-1:0]           txdata,
  output logic                       txclk,
  input  logic                       txready,
  input  logic [WIDTH-1:0]           rxdata,
  output logic                       rxclk,
  input  logic                       rxready,
  input  logic                       rx_rd,
  output logic [WIDTH-1:0]           rx_rdata,
  output logic                       rx_empty,
  output logic                       rx_overflow
);
  // State table
  //   T_IDLE   | waiting for a queued word and txready
  //   T_STROBE | txclk high, STROBE_CYCLES cycles
  //   T_GAP    | txclk low, STROBE_CYCLES cycles
  //   R_IDLE   | watching for an rxready rising edge
  //   R_ACK    | rxclk high, STROBE_CYCLES cycles
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SW-1:0] TC_LOAD = SW'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {T_IDLE, T_STROBE, T_GAP} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;

  tx_state_t tx_state;
  rx_state_t rx_state;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]    rx_count;
  logic [SW-1:0]    tx_tmr, rx_tmr;
  logic             rxready_q;

  logic tx_push, tx_pop, rx_full, rx_rise, rx_push, rx_pop;

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_push  = tx_wr & ~tx_full;
  assign tx_pop   = (tx_state == T_IDLE) && (tx_count != '0) && txready;

  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_rise  = rxready & ~rxready_q;
  assign rx_push  = (rx_state == R_IDLE) && rx_rise && !rx_full;
  assign rx_pop   = rx_rd & ~rx_empty;
  assign rx_rdata = rx_mem[rx_rp];

  // Storage arrays carry no reset; occupancy and pointers define validity.
  always_ff @(posedge hz100) begin
    if (tx_push) tx_mem[tx_wp] <= tx_wdata;
    if (rx_push) rx_mem[rx_wp] <= rxdata;
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      tx_state <= T_IDLE;
      tx_tmr   <= '0;
      txdata   <= '0;
      txclk    <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: if (tx_pop) begin
          txdata   <= tx_mem[tx_rp];
          txclk    <= 1'b1;
          tx_tmr   <= TC_LOAD;
          tx_state <= T_STROBE;
        end
        T_STROBE: if (tx_tmr == '0) begin
          txclk    <= 1'b0;
          tx_tmr   <= TC_LOAD;
          tx_state <= T_GAP;
        end else tx_tmr <= tx_tmr - 1'b1;
        T_GAP: if (tx_tmr == '0) tx_state <= T_IDLE;
               else tx_tmr <= tx_tmr - 1'b1;
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      rx_state    <= R_IDLE;
      rx_tmr      <= '0;
      rxclk       <= 1'b0;
      rx_overflow <= 1'b0;
      rxready_q   <= 1'b0;
    end else begin
      rxready_q <= rxready;
      case (rx_state)
        R_IDLE: if (rx_rise) begin
          if (rx_full) rx_overflow <= 1'b1;
          rxclk    <= 1'b1;
          rx_tmr   <= TC_LOAD;
          rx_state <= R_ACK;
        end
        R_ACK: if (rx_tmr == '0) begin
          rxclk    <= 1'b0;
          rx_state <= R_IDLE;
        end else rx_tmr <= rx_tmr - 1'b1;
        default: rx_state <= R_IDLE;
      endcase
    end
  end
endmodule
